// File: rtl/drone_mission_ctrl.sv
// drone_mission_ctrl: rescue-drone sortie sequencer (idle, init, takeoff,
// zone search, target imaging with retries, capture, return, land, maint).
// Ports: clk/reset (sync, active-high); cmd, sensor_check, err, altitude,
// batt_level, thermal_found, img_pass, target_found, home_reached,
// is_charging, man_ctrl in; state_out, led, zone_idx, capture_count,
// flight_error, maintenance_req, destination, image_scan out.
// Optional macro DRONE_MANUAL_CTRL_EN enables the MANUAL state.
module drone_mission_ctrl #(
    parameter int ALT_W          = 8,
    parameter int CRUISE_ALT     = 64,
    parameter int NUM_ZONES      = 4,
    parameter int ZONE_CYCLES    = 16,
    parameter int CAPTURE_CYCLES = 8,
    parameter int MAX_RETRY      = 2,
    parameter int TAKEOFF_TMO    = 32,
    parameter int BATT_W         = 8,
    parameter int BATT_LOW       = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   cmd,
    input  logic                         sensor_check,
    input  logic                         err,
    input  logic [ALT_W-1:0]             altitude,
    input  logic [BATT_W-1:0]            batt_level,
    input  logic                         thermal_found,
    input  logic [1:0]                   img_pass,
    input  logic                         target_found,
    input  logic                         home_reached,
    input  logic                         is_charging,
    input  logic                         man_ctrl,
    output logic [3:0]                   state_out,
    output logic [3:0]                   led,
    output logic [$clog2(NUM_ZONES)-1:0] zone_idx,
    output logic [7:0]                   capture_count,
    output logic                         flight_error,
    output logic                         maintenance_req,
    output logic                         destination,
    output logic                         image_scan
);

    localparam int ZW    = $clog2(NUM_ZONES);
    localparam int RW    = $clog2(MAX_RETRY + 1);
    localparam int TMR_W = 16;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        TAKEOFF = 4'd2,
        SEARCH  = 4'd3,
        TARGET  = 4'd4,
        CAPTURE = 4'd5,
        RETURN  = 4'd6,
        LAND    = 4'd7,
        MAINT   = 4'd8,
        MANUAL  = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ZW-1:0]    zone_q, zone_d;
    logic [7:0]       cap_q, cap_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             fe_q, fe_d;
    logic             zone_tick;
    logic             in_flight;
    logic             man_req;

    assign in_flight = (state_q inside {TAKEOFF, SEARCH, TARGET,
                                        CAPTURE, RETURN, MANUAL});

`ifdef DRONE_MANUAL_CTRL_EN
    assign man_req = man_ctrl && (state_q inside {TAKEOFF, SEARCH,
                                  TARGET, CAPTURE, RETURN});
`else
    logic unused_man;
    assign unused_man = man_ctrl;
    assign man_req    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            zone_q  <= '0;
            cap_q   <= '0;
            retry_q <= '0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            zone_q  <= zone_d;
            cap_q   <= cap_d;
            retry_q <= retry_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        zone_d    = zone_q;
        cap_d     = cap_q;
        retry_d   = retry_q;
        fe_d      = fe_q;
        zone_tick = 1'b0;

        if (in_flight && err) begin
            state_d = LAND;
            fe_d    = 1'b1;
        end else if (in_flight && (batt_level < BATT_W'(BATT_LOW))
                     && (state_q != RETURN)) begin
            state_d = RETURN;
        end else if (man_req) begin
            state_d = MANUAL;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd == 2'b01) begin
                        state_d = INIT;
                        zone_d  = '0;
                        cap_d   = '0;
                        retry_d = '0;
                    end else if (cmd == 2'b11) begin
                        state_d = MAINT;
                    end
                end
                INIT: begin
                    if (err)               state_d = MAINT;
                    else if (sensor_check) state_d = TAKEOFF;
                end
                TAKEOFF: begin
                    if (altitude >= ALT_W'(CRUISE_ALT)) begin
                        state_d = SEARCH;
                    end else if (timer_q == TMR_W'(TAKEOFF_TMO - 1)) begin
                        state_d = LAND;
                        fe_d    = 1'b1;
                    end
                end
                SEARCH: begin
                    if (target_found) begin
                        state_d = RETURN;
                    end else if (thermal_found) begin
                        state_d = TARGET;
                    end else if (timer_q == TMR_W'(ZONE_CYCLES - 1)) begin
                        // Last zone swept: go home, index stays put
                        if (zone_q == ZW'(NUM_ZONES - 1)) begin
                            state_d = RETURN;
                        end else begin
                            zone_d    = zone_q + 1'b1;
                            zone_tick = 1'b1;
                        end
                    end
                end
                TARGET: begin
                    if (img_pass == 2'b10) begin
                        state_d = CAPTURE;
                        retry_d = '0;
                    end else if (img_pass == 2'b01) begin
                        if (retry_q == RW'(MAX_RETRY - 1)) begin
                            state_d = SEARCH;
                            retry_d = '0;
                        end else begin
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (timer_q == TMR_W'(CAPTURE_CYCLES - 1)) begin
                        state_d = SEARCH;
                        if (cap_q != 8'hff) cap_d = cap_q + 8'd1;
                    end
                end
                RETURN: begin
                    if (home_reached) state_d = LAND;
                end
                LAND: begin
                    if ((altitude == '0) && is_charging)
                        state_d = fe_q ? MAINT : IDLE;
                end
                MAINT: begin
                    if ((cmd == 2'b10) && !err) begin
                        state_d = IDLE;
                        fe_d    = 1'b0;
                    end
                end
`ifdef DRONE_MANUAL_CTRL_EN
                MANUAL: begin
                    if (!man_ctrl) state_d = SEARCH;
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        // One shared timer: restarts on any state change or zone step
        if ((state_d != state_q) || zone_tick)
            timer_d = '0;
        else if (state_q inside {TAKEOFF, SEARCH, CAPTURE})
            timer_d = timer_q + 1'b1;
        else
            timer_d = '0;
    end

    assign state_out       = state_q;
    assign zone_idx        = zone_q;
    assign capture_count   = cap_q;
    assign flight_error    = fe_q;
    assign maintenance_req = (state_q == MAINT);
    assign destination     = (state_q == RETURN) || (state_q == LAND);
    assign image_scan      = (state_q == TARGET) || (state_q == CAPTURE);
    assign led = {flight_error, maintenance_req, destination, image_scan};

endmodule
